uart_buf_rx: RTL and testbench

Word-level UART receiver. Deserialises 8N1 frames on `rxd` and assembles four consecutive bytes, least-significant byte first, into one 32-bit word. It is the receive-side counterpart to the core's 32-bit buffered UART transmitter. It sits between the board RX pin and the core's input path, and hands each completed word over a valid/ack handshake. Bit timing is produced internally from `CLK_PER_HALF_BIT`.

---
 rtl/uart_buf_rx.sv | 253 +++++++++++++++++++++++++
 tb/tb_uart_buf_rx.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_buf_rx.sv
// ---------------------------------------------------------------------------
// uart_buf_rx
//   Word-level 8N1 UART receiver. Four consecutive bytes are assembled
//   least-significant byte first into a 32-bit word. The word is handed to
//   the consumer over a valid/ack handshake. Bit timing comes from
//   CLK_PER_HALF_BIT.
//
// Parameters
//   CLK_PER_HALF_BIT : clock cycles per half UART bit (>= 2).
//   TIMEOUT_BITS     : inter-byte idle limit in bit periods. Only used when
//                      the timeout feature is compiled in.
//
// Optional feature macro
//   UART_BUF_RX_TIMEOUT_EN : when defined, a partial word is discarded after
//                            TIMEOUT_BITS bit periods of inter-byte idle.
//
// Ports
//   clk          in   single clock
//   rstn         in   asynchronous active-low reset
//   rxd          in   serial line, asynchronous to clk, idle high
//   rdata        out  assembled word, first byte in [7:0]
//   rx_buf_valid out  rdata holds an unconsumed word
//   rx_buf_ack   in   consumer accepts the word
//   rx_buf_busy  out  partial word held or frame in progress
//   ferr         out  one-cycle framing-error pulse
//   ovf          out  sticky overrun flag, cleared only by reset
// ---------------------------------------------------------------------------
`ifndef _CLK_PER_HALF_BIT
`define _CLK_PER_HALF_BIT 16
`endif

module uart_buf_rx #(
   parameter int CLK_PER_HALF_BIT = `_CLK_PER_HALF_BIT,
   parameter int TIMEOUT_BITS     = 40
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        rxd,
   output logic [31:0] rdata,
   output logic        rx_buf_valid,
   input  logic        rx_buf_ack,
   output logic        rx_buf_busy,
   output logic        ferr,
   output logic        ovf
);

   localparam int TMR_W = $clog2(2 * CLK_PER_HALF_BIT);
   localparam logic [TMR_W-1:0] HALF_LOAD = TMR_W'(CLK_PER_HALF_BIT - 1);
   localparam logic [TMR_W-1:0] FULL_LOAD = TMR_W'(2 * CLK_PER_HALF_BIT - 1);
   localparam logic [TMR_W-1:0] TMR_ZERO  = {TMR_W{1'b0}};
   localparam logic [TMR_W-1:0] TMR_ONE   = {{(TMR_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   logic             rx_meta_r;
   logic             rxs_r;
   state_t           state_r;
   state_t           state_nxt;
   logic [TMR_W-1:0] timer_r;
   logic [TMR_W-1:0] timer_nxt;
   logic [2:0]       bit_cnt_r;
   logic [2:0]       bit_cnt_nxt;
   logic [7:0]       shift_r;
   logic [7:0]       shift_nxt;
   logic             armed_r;
   logic             armed_nxt;
   logic             start_det_s;
   logic             byte_done_s;
   logic             frame_err_s;
   logic             timeout_s;
   logic [1:0]       byte_idx_r;
   logic [1:0]       byte_idx_nxt;
   logic             word_done_s;
   logic [23:0]      asm_r;

   // Two-flop synchronizer for the asynchronous serial line. Resets low so a
   // genuine high level must be seen before the first start bit is accepted.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rx_meta_r <= 1'b0;
         rxs_r     <= 1'b0;
      end else begin
         rx_meta_r <= rxd;
         rxs_r     <= rx_meta_r;
      end
   end

   // Bit FSM state and datapath registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r   <= S_IDLE;
         timer_r   <= TMR_ZERO;
         bit_cnt_r <= 3'd0;
         shift_r   <= 8'd0;
         armed_r   <= 1'b0;
      end else begin
         state_r   <= state_nxt;
         timer_r   <= timer_nxt;
         bit_cnt_r <= bit_cnt_nxt;
         shift_r   <= shift_nxt;
         armed_r   <= armed_nxt;
      end
   end

   // Bit FSM next-state logic. armed_r blocks start detection until the
   // line has been seen high (after reset and after a framing error).
   always_comb begin
      state_nxt   = state_r;
      timer_nxt   = timer_r;
      bit_cnt_nxt = bit_cnt_r;
      shift_nxt   = shift_r;
      armed_nxt   = armed_r;
      start_det_s = 1'b0;
      byte_done_s = 1'b0;
      frame_err_s = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (rxs_r == 1'b1) begin
               armed_nxt = 1'b1;
            end else if (armed_r) begin
               start_det_s = 1'b1;
               timer_nxt   = HALF_LOAD;
               state_nxt   = S_START;
            end else begin
               armed_nxt = 1'b0;
            end
         end
         S_START: begin
            if (timer_r != TMR_ZERO) begin
               timer_nxt = timer_r - TMR_ONE;
            end else if (rxs_r == 1'b0) begin
               timer_nxt   = FULL_LOAD;
               bit_cnt_nxt = 3'd0;
               state_nxt   = S_DATA;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         S_DATA: begin
            if (timer_r != TMR_ZERO) begin
               timer_nxt = timer_r - TMR_ONE;
            end else begin
               shift_nxt = {rxs_r, shift_r[7:1]};
               timer_nxt = FULL_LOAD;
               if (bit_cnt_r == 3'd7) begin
                  state_nxt = S_STOP;
               end else begin
                  bit_cnt_nxt = bit_cnt_r + 3'd1;
               end
            end
         end
         S_STOP: begin
            if (timer_r != TMR_ZERO) begin
               timer_nxt = timer_r - TMR_ONE;
            end else begin
               state_nxt = S_IDLE;
               if (rxs_r == 1'b1) begin
                  byte_done_s = 1'b1;
               end else begin
                  frame_err_s = 1'b1;
                  armed_nxt   = 1'b0;
               end
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

`ifdef UART_BUF_RX_TIMEOUT_EN
   localparam int TO_LIMIT = TIMEOUT_BITS * 2 * CLK_PER_HALF_BIT;
   localparam int TO_W     = $clog2(TO_LIMIT + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LIMIT - 1);
   localparam logic [TO_W-1:0] TO_ZERO = {TO_W{1'b0}};
   localparam logic [TO_W-1:0] TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};

   logic [TO_W-1:0] idle_cnt_r;

   // Inter-byte idle counter; only runs while a partial word waits in idle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         idle_cnt_r <= TO_ZERO;
      end else if (start_det_s || (state_r != S_IDLE) || (byte_idx_r == 2'd0)) begin
         idle_cnt_r <= TO_ZERO;
      end else if (idle_cnt_r == TO_LAST) begin
         idle_cnt_r <= TO_ZERO;
      end else begin
         idle_cnt_r <= idle_cnt_r + TO_ONE;
      end
   end

   assign timeout_s = (state_r == S_IDLE) && (byte_idx_r != 2'd0) &&
                      (idle_cnt_r == TO_LAST) && !start_det_s;
`else
   assign timeout_s = 1'b0;
`endif

   // Byte lane pointer; a framing error or timeout drops the partial word.
   always_comb begin
      byte_idx_nxt = byte_idx_r;
      word_done_s  = 1'b0;
      if (frame_err_s || timeout_s) begin
         byte_idx_nxt = 2'd0;
      end else if (byte_done_s) begin
         byte_idx_nxt = byte_idx_r + 2'd1;
         word_done_s  = (byte_idx_r == 2'd3);
      end else begin
         byte_idx_nxt = byte_idx_r;
      end
   end

   // Word assembly, output buffer handshake and status flags. The fourth
   // byte bypasses asm_r and goes straight into the completed word.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         byte_idx_r   <= 2'd0;
         asm_r        <= 24'd0;
         rdata        <= 32'd0;
         rx_buf_valid <= 1'b0;
         rx_buf_busy  <= 1'b0;
         ferr         <= 1'b0;
         ovf          <= 1'b0;
      end else begin
         byte_idx_r  <= byte_idx_nxt;
         ferr        <= frame_err_s;
         rx_buf_busy <= (state_nxt != S_IDLE) || (byte_idx_nxt != 2'd0);
         if (byte_done_s) begin
            case (byte_idx_r)
               2'd0:    asm_r[7:0]   <= shift_r;
               2'd1:    asm_r[15:8]  <= shift_r;
               2'd2:    asm_r[23:16] <= shift_r;
               default: asm_r        <= asm_r;
            endcase
         end
         // A same-cycle ack frees the buffer for the incoming word.
         if (word_done_s && (!rx_buf_valid || rx_buf_ack)) begin
            rdata        <= {shift_r, asm_r};
            rx_buf_valid <= 1'b1;
         end else if (word_done_s) begin
            ovf <= 1'b1;
         end else if (rx_buf_valid && rx_buf_ack) begin
            rx_buf_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_buf_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_buf_rx
//   Directed self-checking bench for uart_buf_rx with H=4 (8 clocks per
//   bit). Expected words are queued when a word is sent and compared when
//   the receiver raises rx_buf_valid.
// ---------------------------------------------------------------------------
module tb_uart_buf_rx;

   localparam int H   = 4;
   localparam int BIT = 2 * H;

   logic        clk;
   logic        rstn;
   logic        rxd;
   logic [31:0] rdata;
   logic        rx_buf_valid;
   logic        rx_buf_ack;
   logic        rx_buf_busy;
   logic        ferr;
   logic        ovf;

   int          vectors;
   int          miscompares;
   int          ferr_cycles;
   logic        valid_prev;
   time         rise_t;
   time         start_t;
   logic [31:0] sb[$];

   uart_buf_rx #(
      .CLK_PER_HALF_BIT(H),
      .TIMEOUT_BITS    (4)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .rxd         (rxd),
      .rdata       (rdata),
      .rx_buf_valid(rx_buf_valid),
      .rx_buf_ack  (rx_buf_ack),
      .rx_buf_busy (rx_buf_busy),
      .ferr        (ferr),
      .ovf         (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: counts ferr-high cycles and timestamps each rise of valid.
   initial begin
      ferr_cycles = 0;
      valid_prev  = 1'b0;
      rise_t      = 0;
      forever begin
         @(negedge clk);
         if (ferr === 1'b1) ferr_cycles++;
         if (rx_buf_valid === 1'b1 && valid_prev !== 1'b1) rise_t = $time;
         valid_prev = rx_buf_valid;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      rxd     = 1'b0;
      start_t = $time;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (BIT) @(negedge clk);
      end
      rxd = stop;
      repeat (BIT) @(negedge clk);
      rxd = 1'b1;
   endtask

   task automatic send_word(input logic [31:0] w);
      send_byte(w[7:0], 1'b1);
      send_byte(w[15:8], 1'b1);
      send_byte(w[23:16], 1'b1);
      send_byte(w[31:24], 1'b1);
   endtask

   task automatic wait_word(input string tag, input bit do_ack);
      int          n;
      logic [31:0] exp;
      n = 0;
      while (rx_buf_valid !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_valid"}, {31'd0, rx_buf_valid}, 32'd1);
      check({tag, "_sb_nonempty"}, {31'd0, sb.size() > 0}, 32'd1);
      exp = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
      check({tag, "_rdata"}, rdata, exp);
      if (do_ack) begin
         rx_buf_ack = 1'b1;
         @(negedge clk);
         rx_buf_ack = 1'b0;
         check({tag, "_valid_after_ack"}, {31'd0, rx_buf_valid}, 32'd0);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_rdata"}, rdata, 32'd0);
      check({tag, "_valid"}, {31'd0, rx_buf_valid}, 32'd0);
      check({tag, "_busy"},  {31'd0, rx_buf_busy},  32'd0);
      check({tag, "_ferr"},  {31'd0, ferr},         32'd0);
      check({tag, "_ovf"},   {31'd0, ovf},          32'd0);
   endtask

   initial begin
      int          ferr_before;
      logic [31:0] w;
      vectors     = 0;
      miscompares = 0;
      rstn        = 1'b0;
      rxd         = 1'b1;
      rx_buf_ack  = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values("rst0");
      rstn = 1'b1;
      repeat (10) @(negedge clk);

      // Basic word, back-to-back bytes, plus latency of the final byte.
      sb.push_back(32'h1234_5678);
      send_word(32'h1234_5678);
      check("lat_in_window", {31'd0, ((rise_t - start_t) >= 78 * 10) && ((rise_t - start_t) <= 80 * 10)}, 32'd1);
      repeat (5) @(negedge clk);
      check("basic_valid_held", {31'd0, rx_buf_valid}, 32'd1);
      wait_word("basic", 1'b1);
      check("basic_ferr", ferr_cycles, 32'd0);
      check("basic_ovf", {31'd0, ovf}, 32'd0);
      check("basic_busy", {31'd0, rx_buf_busy}, 32'd0);

      // Glitch shorter than half a bit must not start a frame.
      rxd = 1'b0;
      repeat (2) @(negedge clk);
      rxd = 1'b1;
      repeat (24) @(negedge clk);
      check("glitch_busy", {31'd0, rx_buf_busy}, 32'd0);
      check("glitch_valid", {31'd0, rx_buf_valid}, 32'd0);
      sb.push_back(32'hDEAD_BEEF);
      send_word(32'hDEAD_BEEF);
      wait_word("glitch_word", 1'b1);

      // Framing error on the second byte discards the partial word.
      ferr_before = ferr_cycles;
      send_byte(8'hAA, 1'b1);
      send_byte(8'h55, 1'b0);
      repeat (16) @(negedge clk);
      check("ferr_one_cycle", ferr_cycles - ferr_before, 32'd1);
      check("ferr_busy", {31'd0, rx_buf_busy}, 32'd0);
      check("ferr_valid", {31'd0, rx_buf_valid}, 32'd0);
      sb.push_back(32'h0403_0201);
      send_word(32'h0403_0201);
      wait_word("ferr_word", 1'b1);

      // Overrun: second word dropped while the first is unconsumed.
      sb.push_back(32'hAAAA_AAAA);
      send_word(32'hAAAA_AAAA);
      send_word(32'h5555_5555);
      repeat (4) @(negedge clk);
      check("ovf_set", {31'd0, ovf}, 32'd1);
      wait_word("ovf_first", 1'b1);
      sb.push_back(32'h0000_FFFF);
      send_word(32'h0000_FFFF);
      wait_word("ovf_third", 1'b1);
      check("ovf_sticky", {31'd0, ovf}, 32'd1);

      // Reset in the middle of a word.
      send_byte(8'h99, 1'b1);
      send_byte(8'h88, 1'b1);
      repeat (2) @(negedge clk);
      check("partial_busy", {31'd0, rx_buf_busy}, 32'd1);
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values("rst_mid");
      rstn = 1'b1;
      repeat (10) @(negedge clk);
      sb.push_back(32'h4433_2211);
      send_word(32'h4433_2211);
      wait_word("post_rst", 1'b1);

      // Single byte, long idle, then a full word.
      send_byte(8'h5A, 1'b1);
      repeat (40 * BIT) @(negedge clk);
`ifdef UART_BUF_RX_TIMEOUT_EN
      w = 32'hCAFE_BABE;
`else
      w = 32'hFEBA_BE5A;
`endif
      sb.push_back(w);
      send_word(32'hCAFE_BABE);
      wait_word("timeout", 1'b1);

      check("sb_drained", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
